// File: rtl/waveform_pkg.sv
// Shared constants and types for the waveform renderer slice.
package waveform_pkg;

  localparam int unsigned DEF_H_ACTIVE    = 1920;
  localparam int unsigned DEF_V_ACTIVE    = 1080;
  localparam int unsigned CENTER_ROW      = DEF_V_ACTIVE / 2;
  localparam int unsigned DEF_DECIM       = 4;
  localparam int unsigned DEF_SCALE_SHIFT = 6;
  localparam int unsigned ROW_W           = 11;

  localparam logic [23:0] DEF_FG_COLOR = 24'h00FF00;
  localparam logic [23:0] DEF_BG_COLOR = 24'h000000;
  localparam logic [23:0] GRID_COLOR   = 24'h404040;
  localparam int unsigned GRID_PITCH   = 240;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } cap_state_t;

endpackage

// File: rtl/waveform_bank_ram.sv
// Simple dual-port column RAM: one synchronous write port, one registered read port.
// The bank select is the address MSB.
module waveform_bank_ram #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 11
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1 << AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/waveform_renderer.sv
// Captures one decimated screen-width of audio per frame into a double-buffered column
// RAM and renders it as a thick connected trace. Define WAVEFORM_GRID_EN for a graticule.
module waveform_renderer
  import waveform_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned DECIM       = DEF_DECIM,
  parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter logic [23:0] FG_COLOR    = DEF_FG_COLOR,
  parameter logic [23:0] BG_COLOR    = DEF_BG_COLOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] pix_x,
  input  logic [11:0] pix_y,
  input  logic        pix_de,
  input  logic        pix_hs,
  input  logic        pix_vs,
  output logic [23:0] out_data,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs
);

  localparam int unsigned COL_W = $clog2(H_ACTIVE);
  localparam int unsigned DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned AW    = COL_W + 1;
  localparam logic signed [17:0] CENTER_S  = 18'(V_ACTIVE / 2);
  localparam logic signed [17:0] ROW_MAX_S = 18'(V_ACTIVE - 1);

  cap_state_t r_state, w_state_nx;
  logic             r_vs_d;
  logic             w_fs;
  logic [COL_W-1:0] r_col, w_col_nx, w_wcol;
  logic [DEC_W-1:0] r_dec, w_dec_nx, w_dec_cur;
  logic             r_front, w_front_nx;
  logic             r_valid, w_valid_nx;
  logic             w_we;

  logic signed [15:0] w_shift;
  logic signed [17:0] w_row_s;
  logic [ROW_W-1:0]   w_row;
  logic [ROW_W-1:0]   w_rd;

  assign w_fs    = pix_vs & ~r_vs_d;
  assign s_ready = (r_state == FILL);

  // Sample to plot row, clamped so odd parameter sets cannot address off-screen rows.
  assign w_shift = $signed(s_data) >>> SCALE_SHIFT;
  assign w_row_s = CENTER_S - 18'(w_shift);

  always_comb begin
    if (w_row_s < 18'sd0) begin
      w_row = '0;
    end else if (w_row_s > ROW_MAX_S) begin
      w_row = ROW_MAX_S[ROW_W-1:0];
    end else begin
      w_row = w_row_s[ROW_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_vs_d  <= 1'b0;
      r_col   <= '0;
      r_dec   <= '0;
      r_front <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_vs_d  <= pix_vs;
      r_col   <= w_col_nx;
      r_dec   <= w_dec_nx;
      r_front <= w_front_nx;
      r_valid <= w_valid_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_col_nx   = r_col;
    w_dec_nx   = r_dec;
    w_front_nx = r_front;
    w_valid_nx = r_valid;
    w_we       = 1'b0;
    w_wcol     = r_col;
    w_dec_cur  = r_dec;
    unique case (r_state)
      IDLE: begin
        if (w_fs) begin
          w_state_nx = FILL;
          w_col_nx   = '0;
          w_dec_nx   = '0;
        end
      end
      FILL: begin
        // A frame start mid-fill restarts the capture; a sample accepted in that
        // same cycle is treated as the first sample of the new capture.
        w_wcol    = w_fs ? '0 : r_col;
        w_dec_cur = w_fs ? '0 : r_dec;
        w_col_nx  = w_wcol;
        w_dec_nx  = w_dec_cur;
        if (s_valid) begin
          w_dec_nx = (w_dec_cur == DEC_W'(DECIM - 1)) ? '0 : w_dec_cur + DEC_W'(1);
          if (w_dec_cur == '0) begin
            w_we = 1'b1;
            if (w_wcol == COL_W'(H_ACTIVE - 1)) begin
              w_state_nx = DONE;
            end else begin
              w_col_nx = w_wcol + COL_W'(1);
            end
          end
        end
      end
      DONE: begin
        if (w_fs) begin
          w_state_nx = FILL;
          w_front_nx = ~r_front;
          w_valid_nx = 1'b1;
          w_col_nx   = '0;
          w_dec_nx   = '0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  waveform_bank_ram #(
    .AW (AW),
    .DW (ROW_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({~r_front, w_wcol}),
    .i_wdata (w_row),
    .i_raddr ({r_front, pix_x[COL_W-1:0]}),
    .o_rdata (w_rd)
  );

  // Stage 1: coordinates and syncs travel alongside the RAM read.
  logic [11:0]      r_x1, r_y1;
  logic             r_de1, r_hs1, r_vs1, r_valid1;
  logic [ROW_W-1:0] r_prev;
`ifdef WAVEFORM_GRID_EN
  logic             r_grid1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x1     <= '0;
      r_y1     <= '0;
      r_de1    <= 1'b0;
      r_hs1    <= 1'b0;
      r_vs1    <= 1'b0;
      r_valid1 <= 1'b0;
      r_prev   <= '0;
`ifdef WAVEFORM_GRID_EN
      r_grid1  <= 1'b0;
`endif
    end else begin
      r_x1     <= pix_x;
      r_y1     <= pix_y;
      r_de1    <= pix_de;
      r_hs1    <= pix_hs;
      r_vs1    <= pix_vs;
      r_valid1 <= r_valid;
      r_prev   <= w_rd;
`ifdef WAVEFORM_GRID_EN
      r_grid1  <= ((pix_x % 12'(GRID_PITCH)) == '0) || (pix_y == 12'(V_ACTIVE / 2));
`endif
    end
  end

  // Stage 2: r_prev holds the read for the preceding pixel of the raster.
  logic [ROW_W-1:0] w_prv, w_lo, w_hi;
  logic [12:0]      w_y13;
  logic             w_hit;
  logic [23:0]      w_color;

  assign w_prv = (r_x1 == '0) ? w_rd : r_prev;
  assign w_lo  = (w_prv < w_rd) ? w_prv : w_rd;
  assign w_hi  = (w_prv < w_rd) ? w_rd : w_prv;
  assign w_y13 = {1'b0, r_y1};
  assign w_hit = ((w_y13 + 13'd1) >= {2'b00, w_lo}) && (w_y13 <= ({2'b00, w_hi} + 13'd1));

  always_comb begin
    w_color = BG_COLOR;
`ifdef WAVEFORM_GRID_EN
    if (r_grid1) begin
      w_color = GRID_COLOR;
    end
`endif
    if (r_valid1 && w_hit) begin
      w_color = FG_COLOR;
    end
    if (!r_de1) begin
      w_color = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_de   <= 1'b0;
      out_hs   <= 1'b0;
      out_vs   <= 1'b0;
    end else begin
      out_data <= w_color;
      out_de   <= r_de1;
      out_hs   <= r_hs1;
      out_vs   <= r_vs1;
    end
  end

endmodule

// File: tb/tb_waveform_renderer.sv
// Randomized self-checking bench for waveform_renderer against a frame-level reference model.
module tb_waveform_renderer;

  localparam int H     = 1920;
  localparam int V     = 1080;
  localparam int DEC   = 4;
  localparam int DIV   = 64;
  localparam logic [23:0] FG   = 24'h00FF00;
  localparam logic [23:0] BG   = 24'h000000;
  localparam logic [23:0] GRID = 24'h404040;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] pix_x, pix_y;
  logic        pix_de, pix_hs, pix_vs;
  logic [23:0] out_data;
  logic        out_de, out_hs, out_vs;

  always #5 clk = ~clk;

  waveform_renderer dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_de   (pix_de),
    .pix_hs   (pix_hs),
    .pix_vs   (pix_vs),
    .out_data (out_data),
    .out_de   (out_de),
    .out_hs   (out_hs),
    .out_vs   (out_vs)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the capture and of what is on screen.
  int bank [2][H];
  int m_front, m_cnt, m_wr;
  bit m_fill, m_done, m_valid, m_vs_prev;

  typedef struct {
    logic [23:0] d;
    logic de, hs, vs;
  } exp_t;
  exp_t exp_q[$];

  function automatic int row_of(logic [15:0] d);
    int s, q, r;
    s = int'($signed(d));
    q = s / DIV;
    if (s < 0 && q * DIV != s) q = q - 1;
    r = V / 2 - q;
    if (r < 0) r = 0;
    if (r > V - 1) r = V - 1;
    return r;
  endfunction

  function automatic logic [23:0] exp_pixel(int x, int y, bit de);
    int cur, prv, lo, hi;
    logic [23:0] c;
    if (!de) return 24'h0;
    cur = bank[m_front][x];
    prv = (x == 0) ? cur : bank[m_front][x-1];
    lo  = ((prv < cur) ? prv : cur) - 1;
    hi  = ((prv < cur) ? cur : prv) + 1;
    c   = BG;
`ifdef WAVEFORM_GRID_EN
    if (x % 240 == 0 || y == V / 2) c = GRID;
`endif
    if (m_valid && y >= lo && y <= hi) c = FG;
    return c;
  endfunction

  task automatic model_step();
    bit fs;
    fs = pix_vs && !m_vs_prev;
    m_vs_prev = pix_vs;
    if (m_fill) begin
      if (fs) begin
        m_cnt = 0;
        m_wr  = 0;
      end
      if (s_valid) begin
        if (m_cnt % DEC == 0) begin
          bank[1-m_front][m_cnt/DEC] = row_of(s_data);
          m_wr++;
          if (m_wr == H) begin
            m_fill = 0;
            m_done = 1;
          end
        end
        m_cnt++;
      end
    end else if (fs) begin
      if (m_done) begin
        m_front = 1 - m_front;
        m_valid = 1;
      end
      m_fill = 1;
      m_done = 0;
      m_cnt  = 0;
      m_wr   = 0;
    end
  endtask

  // One clock: predict, advance model, clock, then compare against the 2-deep pipeline.
  task automatic tick();
    exp_t e;
    e.d  = exp_pixel(int'(pix_x), int'(pix_y), pix_de);
    e.de = pix_de;
    e.hs = pix_hs;
    e.vs = pix_vs;
    exp_q.push_back(e);
    check_eq("s_ready", {31'b0, s_ready}, {31'b0, m_fill});
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check_eq("out_data", {8'b0, out_data}, {8'b0, e.d});
      check_eq("out_de", {31'b0, out_de}, {31'b0, e.de});
      check_eq("out_hs", {31'b0, out_hs}, {31'b0, e.hs});
      check_eq("out_vs", {31'b0, out_vs}, {31'b0, e.vs});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0;
    pix_x = '0; pix_y = '0; pix_de = 1'b0; pix_hs = 1'b0; pix_vs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_data", {8'b0, out_data}, 32'h0);
    check_eq("rst_out_de", {31'b0, out_de}, 32'h0);
    check_eq("rst_out_hs", {31'b0, out_hs}, 32'h0);
    check_eq("rst_out_vs", {31'b0, out_vs}, 32'h0);
    check_eq("rst_s_ready", {31'b0, s_ready}, 32'h0);
    m_fill = 0; m_done = 0; m_valid = 0; m_front = 0;
    m_cnt = 0; m_wr = 0; m_vs_prev = 0;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic frame_pulse();
    s_valid = 1'b0;
    pix_de = 1'b0; pix_hs = 1'b0;
    pix_vs = 1'b1; tick(); tick();
    pix_vs = 1'b0; tick();
  endtask

  task automatic capture(input int mode, input int ncols, input int pct_valid);
    int budget;
    budget = 20000;
    pix_de = 1'b0; pix_hs = 1'b0; pix_vs = 1'b0;
    while (m_fill && m_wr < ncols && budget > 0) begin
      s_valid = (int'($urandom_range(0, 99)) < pct_valid);
      case (mode)
        0:       s_data = 16'h0000;
        1:       s_data = (m_wr < H / 2) ? 16'h7FFF : 16'h8000;
        default: s_data = 16'($urandom);
      endcase
      tick();
      budget--;
    end
    s_valid = 1'b0;
    if (budget == 0) check_eq("capture_timeout", m_wr, ncols);
  endtask

  task automatic run(input int y, input int xs, input int xe);
    pix_y = 12'(y); pix_hs = 1'b0; pix_vs = 1'b0;
    if (xs > 0) begin
      pix_x = 12'(xs - 1); pix_de = 1'b0; tick();
    end
    for (int x = xs; x <= xe; x++) begin
      pix_x = 12'(x); pix_de = 1'b1; tick();
    end
    pix_de = 1'b0; tick(); tick();
  endtask

  task automatic near_trace_runs(input int n);
    for (int k = 0; k < n; k++) begin
      int xs, yc;
      xs = int'($urandom_range(0, H - 65));
      yc = bank[m_front][xs] + int'($urandom_range(0, 6)) - 3;
      if (yc < 0) yc = 0;
      if (yc > V - 1) yc = V - 1;
      run(yc, xs, xs + 63);
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < H; c++) bank[b][c] = 0;

    do_reset();

    // No frame start yet: samples offered must not be accepted.
    for (int k = 0; k < 50; k++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      tick();
    end
    s_valid = 1'b0;
    run(100, 0, 63);

    // Three frames with no samples: screen stays background.
    for (int f = 0; f < 3; f++) begin
      frame_pulse();
      run(int'($urandom_range(0, V - 1)), int'($urandom_range(0, 1800)), 1863);
    end

    // Flat zero trace.
    capture(0, H, 100);
    frame_pulse();
    run(539, 0, H - 1);
    run(538, 500, 627);
    run(541, 1700, 1827);
    run(542, 0, 127);
    run(0, 0, 31);
    run(V - 1, H - 32, H - 1);

    // Full-scale positive half, full-scale negative half.
    capture(1, H, 88);
    frame_pulse();
    for (int y = 24; y <= 1056; y++) run(y, 958, 962);
    run(29, 900, 1000);
    run(1052, 900, 1000);
    run(28, 0, 63);

    // Partial capture then frame start: no swap, restart at column 0.
    capture(2, 1000, 75);
    frame_pulse();
    run(29, 900, 1000);
    run(1052, 950, 970);
    capture(2, H, 75);
    frame_pulse();
    near_trace_runs(24);

    // Sync/data-enable alignment with arbitrary raster traffic.
    pix_x = '0;
    for (int k = 0; k < 400; k++) begin
      pix_x  = 12'((int'(pix_x) + 1) % H);
      pix_y  = 12'($urandom_range(0, V - 1));
      pix_de = 1'($urandom_range(0, 1));
      pix_hs = 1'($urandom_range(0, 1));
      pix_vs = 1'($urandom_range(0, 1));
      tick();
    end
    pix_de = 1'b0; pix_hs = 1'b0; pix_vs = 1'b0;
    tick(); tick();

    // Reset in the middle of a capture abandons it and clears the valid flag.
    frame_pulse();
    capture(2, 100, 100);
    do_reset();
    tick();
    frame_pulse();
    run(540, 0, 200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
